// File: rtl/apb_timer_if.sv
// APB completer-side bus bundle between the AXI-to-APB bridge and the timer.
// Latency: none; this file only groups wires.
// Backpressure: none; pready is driven by the completer.
// Ports: psel/penable/pwrite/paddr/pwdata from the bridge; prdata/pready back to it.
interface apb_timer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready
  );
endinterface

// File: rtl/apb_timer.sv
// APB timer: prescaled 32-bit up-counter with compare match, overflow and level irq.
// Latency: zero-wait-state APB (pready = psel & penable); irq registered one cycle after status.
// Backpressure: none; every access completes in its access phase.
// Ports: clk, rst_n (async active-low), apb (slave modport of apb_timer_if), irq (level).
module apb_timer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  apb_timer_if.slave apb,
  output logic       irq
);

  localparam int PW = PRESCALE_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

  // Register state
  logic                  ctrl_en, ctrl_ar, ctrl_ie;
  logic [DATA_WIDTH-1:0] count, compare;
  logic                  st_match, st_ovf;
  logic [PW-1:0]         prescale, pre_cnt;

  // Address decode; only paddr[7:0] matter
  logic [1:0] lane;
  logic [5:0] word;
  logic       unused_paddr;
  assign lane         = apb.paddr[1:0];
  assign word         = apb.paddr[7:2];
  assign unused_paddr = ^apb.paddr[ADDR_WIDTH-1:8];

  logic wr, wr_ctrl, wr_count, wr_compare, wr_status, wr_prescale;
  assign wr          = apb.psel & apb.penable & apb.pwrite;
  assign wr_ctrl     = wr & (word == 6'd0);
  assign wr_count    = wr & (word == 6'd1);
  assign wr_compare  = wr & (word == 6'd2);
  assign wr_status   = wr & (word == 6'd3);
  assign wr_prescale = wr & (word == 6'd4);

  // Byte-lane write data: offset 0 is a full word, otherwise only lane n
  // is written and it takes pwdata[7:0] (bridge right-aligns sub-word data).
  logic [DATA_WIDTH-1:0] wmask, wval;
  always_comb begin
    wmask = '1;
    wval  = apb.pwdata;
    if (lane != 2'd0) begin
      wmask = DATA_WIDTH'(8'hFF) << {lane, 3'b000};
      wval  = DATA_WIDTH'(apb.pwdata[7:0]) << {lane, 3'b000};
    end
  end

  // Prescaler tick and counter events
  logic tick, cmp_eq, match_set, ovf_set;
  assign tick      = ctrl_en & (pre_cnt == prescale);
  assign cmp_eq    = (count == compare);
  assign match_set = tick & cmp_eq;
  assign ovf_set   = tick & ~cmp_eq & (count == ALL_ONES);

  // Next-state values
  logic [DATA_WIDTH-1:0] count_d, compare_d;
  logic [PW-1:0]         prescale_d, pre_cnt_d;
  logic [2:0]            ctrl_d;
  logic [1:0]            clr;

  always_comb begin
    count_d = count;
    if (tick) begin
      if (cmp_eq)                count_d = ctrl_ar ? '0 : count;
      else if (count == ALL_ONES) count_d = '0;
      else                        count_d = count + DATA_WIDTH'(1);
    end
    // A bus write to COUNT overrides whatever the tick would have done
    if (wr_count) count_d = (count & ~wmask) | (wval & wmask);

    compare_d = compare;
    if (wr_compare) compare_d = (compare & ~wmask) | (wval & wmask);

    prescale_d = prescale;
    if (wr_prescale) prescale_d = (prescale & ~wmask[PW-1:0]) | (wval[PW-1:0] & wmask[PW-1:0]);

    // CTRL bits live in byte lane 0 only
    ctrl_d = {ctrl_ie, ctrl_ar, ctrl_en};
    if (wr_ctrl && wmask[0]) ctrl_d = wval[2:0];
    // One-shot match disables the timer even if the bus writes EN this cycle
    if (match_set && !ctrl_ar) ctrl_d[0] = 1'b0;

    clr = (wr_status && wmask[0]) ? wval[1:0] : 2'b00;

    // Held at 0 while disabled, so an EN 0->1 write always starts from 0.
    // A PRESCALE lowered below pre_cnt lets pre_cnt run on to its natural wrap.
    pre_cnt_d = '0;
    if (ctrl_en && !tick) pre_cnt_d = pre_cnt + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_en  <= 1'b0;
      ctrl_ar  <= 1'b0;
      ctrl_ie  <= 1'b0;
      count    <= '0;
      compare  <= '0;
      st_match <= 1'b0;
      st_ovf   <= 1'b0;
      prescale <= '0;
      pre_cnt  <= '0;
      irq      <= 1'b0;
    end else begin
      {ctrl_ie, ctrl_ar, ctrl_en} <= ctrl_d;
      count    <= count_d;
      compare  <= compare_d;
      prescale <= prescale_d;
      pre_cnt  <= pre_cnt_d;
      // Hardware set beats a same-cycle W1C
      st_match <= (st_match & ~clr[0]) | match_set;
      st_ovf   <= (st_ovf   & ~clr[1]) | ovf_set;
      irq      <= ctrl_ie & (st_match | st_ovf);
    end
  end

  // Read path: combinational, shifted down by the byte offset
  logic [DATA_WIDTH-1:0] rd_reg;
  always_comb begin
    rd_reg = '0;
    case (word)
      6'd0:    rd_reg = DATA_WIDTH'({ctrl_ie, ctrl_ar, ctrl_en});
      6'd1:    rd_reg = count;
      6'd2:    rd_reg = compare;
      6'd3:    rd_reg = DATA_WIDTH'({st_ovf, st_match});
      6'd4:    rd_reg = DATA_WIDTH'(prescale);
      default: rd_reg = '0;
    endcase
  end

  assign apb.prdata = (apb.psel & ~apb.pwrite) ? (rd_reg >> {lane, 3'b000}) : '0;
  assign apb.pready = apb.psel & apb.penable;

endmodule

// File: tb/tb_apb_timer.sv
module tb_apb_timer;

  logic clk;
  logic rst_n;
  logic irq;
  int   total = 0;
  int   bad   = 0;

  apb_timer_if bus ();

  apb_timer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .apb   (bus),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Write: setup, access, commit on the following edge
  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  // Read: sample prdata/pready in the access phase
  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d, output logic rdy);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #1;
    d   = bus.prdata;
    rdy = bus.pready;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic check_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        rdy;
    apb_rd(a, d, rdy);
    check(tag, d, exp);
    check({tag, "_pready"}, {31'b0, rdy}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;

    // Reset state
    #12;
    check("rst_irq",    {31'b0, irq},        32'd0);
    check("rst_pready", {31'b0, bus.pready}, 32'd0);
    check("rst_prdata", bus.prdata,          32'd0);
    @(negedge clk); rst_n = 1'b1;
    check_rd("rd_ctrl0",  32'h00, 32'h0);
    check_rd("rd_count0", 32'h04, 32'h0);
    check_rd("rd_cmp0",   32'h08, 32'h0);
    check_rd("rd_stat0",  32'h0C, 32'h0);
    check_rd("rd_pre0",   32'h10, 32'h0);
    check("irq0", {31'b0, irq}, 32'd0);

    // Auto-reload: tick every 4 cycles, match 24 cycles after enable
    apb_wr(32'h10, 32'd3);
    apb_wr(32'h08, 32'd5);
    apb_wr(32'h00, 32'h7);
    repeat (24) @(posedge clk);
    #1 check("ar_irq_before", {31'b0, irq}, 32'd0);
    @(posedge clk);
    #1 check("ar_irq_rise", {31'b0, irq}, 32'd1);
    check_rd("ar_count", 32'h04, 32'd0);
    check_rd("ar_status", 32'h0C, 32'h1);
    apb_wr(32'h0C, 32'h1);
    check("ar_irq_at_clr", {31'b0, irq}, 32'd1);
    @(posedge clk);
    #1 check("ar_irq_after_clr", {31'b0, irq}, 32'd0);
    apb_wr(32'h00, 32'h0);
    apb_wr(32'h0C, 32'h3);
    apb_wr(32'h04, 32'h0);

    // One-shot
    apb_wr(32'h10, 32'd0);
    apb_wr(32'h08, 32'd2);
    apb_wr(32'h00, 32'h5);
    repeat (4) @(posedge clk);
    check_rd("os_count", 32'h04, 32'd2);
    check_rd("os_ctrl",  32'h00, 32'h4);
    check_rd("os_status", 32'h0C, 32'h1);
    check("os_irq", {31'b0, irq}, 32'd1);
    apb_wr(32'h00, 32'h0);
    apb_wr(32'h0C, 32'h3);

    // Overflow
    apb_wr(32'h04, 32'hFFFF_FFFE);
    apb_wr(32'h08, 32'h10);
    apb_wr(32'h00, 32'h1);
    check_rd("ovf_count",  32'h04, 32'd0);
    check_rd("ovf_status", 32'h0C, 32'h2);
    apb_wr(32'h00, 32'h0);
    apb_wr(32'h0C, 32'h3);
    apb_wr(32'h04, 32'h0);
    check("ovf_irq_off", {31'b0, irq}, 32'd0);

    // Byte lanes
    apb_wr(32'h08, 32'h1122_3344);
    apb_wr(32'h0A, 32'h5555_55AB);
    check_rd("byte_cmp",    32'h08, 32'h11AB_3344);
    check_rd("byte_rd_b3",  32'h0B, 32'h0000_0011);
    check_rd("byte_rd_b1",  32'h09, 32'h0011_AB33);
    check_rd("unmapped_rd", 32'h20, 32'h0);

    // W1C on the same edge as a one-shot match: match wins
    apb_wr(32'h08, 32'd2);
    apb_wr(32'h00, 32'h1);
    apb_wr(32'h0C, 32'h1);
    check_rd("w1c_vs_set", 32'h0C, 32'h1);
    check_rd("w1c_ctrl",   32'h00, 32'h0);
    apb_wr(32'h0C, 32'h3);
    apb_wr(32'h04, 32'h0);

    // COUNT write on a tick edge: bus write wins
    apb_wr(32'h10, 32'd3);
    apb_wr(32'h08, 32'h1000_0000);
    apb_wr(32'h00, 32'h1);
    @(posedge clk);
    apb_wr(32'h04, 32'h100);
    check_rd("cnt_wr_vs_tick", 32'h04, 32'h100);
    apb_wr(32'h00, 32'h0);

    // Reset mid-count with irq high
    apb_wr(32'h10, 32'd0);
    apb_wr(32'h08, 32'd2);
    apb_wr(32'h04, 32'd0);
    apb_wr(32'h0C, 32'h3);
    apb_wr(32'h00, 32'h7);
    repeat (5) @(posedge clk);
    #1 check("pre_rst_irq", {31'b0, irq}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("mid_rst_irq", {31'b0, irq}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    check_rd("post_rst_ctrl",  32'h00, 32'h0);
    check_rd("post_rst_count", 32'h04, 32'h0);
    check_rd("post_rst_cmp",   32'h08, 32'h0);
    check_rd("post_rst_stat",  32'h0C, 32'h0);
    check_rd("post_rst_pre",   32'h10, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_timer.md
Name: apb_timer

Overview:
- 32-bit APB timer/compare peripheral sitting directly downstream of the AXI-to-APB bridge; consumes its psel/penable/pwrite/paddr/pwdata strobes and returns prdata/pready.
- Provides a prescaled up-counter, compare match, overflow detection, one-shot or auto-reload modes, and a level interrupt to the CPU interrupt controller.
- Honours the bridge's byte-lane convention: write data arrives right-aligned to paddr[1:0]; read data is returned right-shifted by paddr[1:0].

Parameters:
- ADDR_WIDTH, 32, width of paddr.
- DATA_WIDTH, 32, width of pwdata/prdata; only 32 is supported.
- PRESCALE_WIDTH, 16, width of the PRESCALE register and the internal prescale counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_WIDTH  byte address; paddr[7:2] decoded, upper bits ignored.
- pwdata  in  DATA_WIDTH  write data, right-aligned to paddr[1:0].
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- irq  out  1  level interrupt.

Behaviour:
- Reset: all registers 0, prescale counter 0. Outputs: prdata=0, pready=0, irq=0.
- Register map (word offsets):
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x04 COUNT: 32 bit, RW.
  - 0x08 COMPARE: 32 bit, RW.
  - 0x0C STATUS: [0] MATCH, [1] OVF; write-1-to-clear.
  - 0x10 PRESCALE: PRESCALE_WIDTH bits, RW.
  - Other offsets: read 0, writes ignored.
- APB handshake:
  - pready = psel & penable, combinational; zero wait states; no pslverr.
  - Writes commit on the clock edge where psel & penable & pwrite.
  - prdata is combinational: (selected register >> 8*paddr[1:0]) when psel & ~pwrite, else 0.
- Byte lanes for writes:
  - paddr[1:0]==0: full 32-bit write.
  - paddr[1:0]==n≠0: only byte lane n is written, taking pwdata[7:0].
- Prescaler:
  - When EN=1, pre_cnt counts 0..PRESCALE and then wraps to 0.
  - A tick is asserted in the cycle where pre_cnt==PRESCALE. PRESCALE=0 gives a tick every cycle.
  - When EN=0, pre_cnt is held at 0.
- On a tick:
  - If COUNT==COMPARE: MATCH<=1. If AUTO_RELOAD=1, COUNT<=0. Otherwise EN<=0 and COUNT holds.
  - Else if COUNT==0xFFFFFFFF: COUNT<=0, OVF<=1.
  - Else COUNT<=COUNT+1.
- irq: registered; irq <= IRQ_EN & (MATCH | OVF). It rises one cycle after the status bit sets.
- Simultaneous events:
  - An APB write to COUNT in the same cycle as a tick: the APB write wins.
  - A STATUS W1C in the same cycle as a hardware set: the set wins.
  - A CTRL write clearing EN in the same cycle as a one-shot match: EN=0 either way; MATCH still sets.
  - A CTRL write with EN 0->1 restarts pre_cnt at 0.
  - A write to PRESCALE while running: the new value is used for comparison from the next cycle. If pre_cnt > new PRESCALE, pre_cnt continues counting to its full-width wrap and then to 0.
- Reset asserted mid-transfer or mid-count: immediate return to reset values; no partial write is retained.

Test Plan:
- Reset, then read all 5 registers -> every read returns 0x00000000, pready=1 in each access phase, irq=0.
- PRESCALE=3, COMPARE=5, CTRL=0x7 (EN, auto-reload, IRQ_EN) -> tick every 4 cycles; MATCH sets 24 cycles after enable; COUNT returns to 0; irq=1 one cycle later; write 0x1 to STATUS -> irq=0 the cycle after the clear.
- One-shot: PRESCALE=0, COMPARE=2, CTRL=0x5 -> COUNT stops at 2, CTRL reads 0x4, MATCH=1.
- Overflow: COUNT=0xFFFFFFFE, COMPARE=0x10, PRESCALE=0, CTRL=0x1 -> after 2 ticks COUNT=0, STATUS=0x2.
- Byte access: write COMPARE=0x11223344, then write to paddr=0x0A with pwdata=0xAB -> COMPARE=0x11AB3344; read paddr=0x0B -> prdata=0x00000011; unmapped read at 0x20 -> 0.
- Collisions:
  - Force a STATUS W1C on the same cycle as a match -> MATCH remains 1.
  - COUNT write on a tick cycle -> COUNT equals the written value.
  - Assert rst_n low mid-count -> all registers 0 and irq=0 immediately.
